// File: rtl/i2c_tx_burst.sv
// rtl/i2c_tx_burst.sv - I2C controller write engine: START, {addr,W}, LEN FIFO bytes, STOP, with abort and stretching
module i2c_tx_burst #(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int LEN_W      = 8
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             wr_en_i,
   input  logic [7:0]       wr_data_i,
   output logic             full_o,
   output logic             empty_o,
   input  logic             start_i,
   input  logic [6:0]       addr_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             nak_o,
   output logic             err_o,
   output logic [LEN_W-1:0] ack_cnt_o,
   input  logic             scl_i,
   input  logic             sda_i,
   output logic             scl_oe_o,
   output logic             sda_oe_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = $clog2(CLK_DIV);

   typedef enum logic [2:0] {S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP} state_e;

   state_e           state_q, state_d;
   logic [1:0]       qtr_q, qtr_d;
   logic [DW-1:0]    div_q;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [6:0]       addr_q, addr_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] ack_cnt_q, ack_cnt_d;
   logic             nak_q, nak_d, err_q, err_d, done_q, done_d;
   logic             scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
   logic             hold, tick, pop, push, load;

   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      cnt_q, cnt_d;
   logic             full_q, empty_q;

   // A target holding SCL low while we release it freezes the quarter divider
   assign hold = ((qtr_q == 2'd1) || (qtr_q == 2'd2)) && !scl_oe_q && !scl_i;
   assign tick = (state_q != S_IDLE) && !hold && (div_q == DW'(CLK_DIV - 1));
   assign push = wr_en_i && (cnt_q != (AW+1)'(FIFO_DEPTH));

   // FIFO storage, written on every accepted push
   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr_q] <= wr_data_i;
   end

   // FIFO pointers and count; full/empty registered from the next count
   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
      else if (!push && pop) cnt_d = cnt_q - (AW+1)'(1);
   end

   // FIFO control registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == (AW+1)'(FIFO_DEPTH));
         empty_q <= (cnt_d == '0);
      end
   end

   // State register: FSM, divider, shifter, status and the registered pad enables
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= S_IDLE;
         qtr_q     <= 2'd0;
         div_q     <= '0;
         bit_q     <= 3'd0;
         shift_q   <= 8'd0;
         addr_q    <= 7'd0;
         len_q     <= '0;
         ack_cnt_q <= '0;
         nak_q     <= 1'b0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         scl_oe_q  <= 1'b0;
         sda_oe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         qtr_q     <= qtr_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         ack_cnt_q <= ack_cnt_d;
         nak_q     <= nak_d;
         err_q     <= err_d;
         done_q    <= done_d;
         if (state_q == S_IDLE) div_q <= '0;
         else if (!hold)        div_q <= tick ? '0 : div_q + DW'(1);
         if (tick) begin
            scl_oe_q <= scl_oe_d;
            sda_oe_q <= sda_oe_d;
         end
      end
   end

   // Next state: quarter/phase sequencing, ACK sampling at Q2, byte loading at phase boundaries
   always_comb begin
      state_d   = state_q;
      qtr_d     = qtr_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      addr_d    = addr_q;
      len_d     = len_q;
      ack_cnt_d = ack_cnt_q;
      nak_d     = nak_q;
      err_d     = err_q;
      done_d    = 1'b0;
      pop       = 1'b0;
      load      = 1'b0;
      if (state_q == S_IDLE) begin
         qtr_d = 2'd0;
         if (start_i) begin
            state_d   = S_START;
            addr_d    = addr_i;
            len_d     = len_i;
            ack_cnt_d = '0;
            nak_d     = 1'b0;
            err_d     = 1'b0;
         end
      end else if (tick) begin
         qtr_d = qtr_q + 2'd1;
         if (qtr_q == 2'd2) begin
            if (state_q == S_AACK && sda_i) nak_d = 1'b1;
            if (state_q == S_DACK) begin
               if (sda_i) nak_d = 1'b1;
               else       ack_cnt_d = ack_cnt_q + LEN_W'(1);
            end
         end
         if (qtr_q == 2'd3) begin
            case (state_q)
               S_START: begin
                  state_d = S_ADDR;
                  bit_d   = 3'd7;
                  shift_d = {addr_q, 1'b0};
               end
               S_ADDR, S_DATA: begin
                  if (bit_q == 3'd0) begin
                     state_d = (state_q == S_ADDR) ? S_AACK : S_DACK;
                  end else begin
                     bit_d   = bit_q - 3'd1;
                     shift_d = {shift_q[6:0], 1'b0};
                  end
               end
               S_AACK:  if (nak_q || len_q == '0) state_d = S_STOP; else load = 1'b1;
               S_DACK:  if (nak_q || ack_cnt_q == len_q) state_d = S_STOP; else load = 1'b1;
               S_STOP: begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
               default: state_d = S_IDLE;
            endcase
            // The byte is popped as DATA bit 7 begins so SDA carries its MSB from Q0
            if (load) begin
               if (empty_q) begin
                  err_d   = 1'b1;
                  state_d = S_STOP;
               end else begin
                  pop     = 1'b1;
                  state_d = S_DATA;
                  bit_d   = 3'd7;
                  shift_d = fifo_mem[rd_ptr_q];
               end
            end
         end
      end
   end

   // Output decode: pad enables for the quarter being entered, latched on the tick
   always_comb begin
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
      case (state_d)
         S_START: begin
            sda_oe_d = (qtr_d != 2'd0);
            scl_oe_d = (qtr_d == 2'd3);
         end
         S_ADDR, S_DATA: begin
            scl_oe_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
            sda_oe_d = ~shift_d[7];
         end
         S_AACK, S_DACK: scl_oe_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
         S_STOP: begin
            scl_oe_d = (qtr_d == 2'd0);
            sda_oe_d = (qtr_d <= 2'd1);
         end
         default: ;
      endcase
   end

   assign full_o    = full_q;
   assign empty_o   = empty_q;
   assign busy_o    = (state_q != S_IDLE);
   assign done_o    = done_q;
   assign nak_o     = nak_q;
   assign err_o     = err_q;
   assign ack_cnt_o = ack_cnt_q;
   assign scl_oe_o  = scl_oe_q;
   assign sda_oe_o  = sda_oe_q;
endmodule

// File: tb/tb_i2c_tx_burst.sv
// tb/tb_i2c_tx_burst.sv - directed bench for i2c_tx_burst with an I2C target model
module tb_i2c_tx_burst;
   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'd0;
   logic       full, empty;
   logic       start = 1'b0;
   logic [6:0] addr = 7'd0;
   logic [7:0] len = 8'd0;
   logic       busy, done, nak, err;
   logic [7:0] ack_cnt;
   logic       scl_oe, sda_oe;

   int tests = 0;
   int fails = 0;

   // target model state
   logic       scl_d1 = 1'b1, sda_d1 = 1'b1;
   int         bitn = 0, byten = 0, st_cnt = 0, done_cnt = 0, stop_cnt = 0;
   logic [7:0] sr = 8'd0;
   logic [7:0] bus [0:15];
   logic       tgt_sda = 1'b0, stretch = 1'b0, stretch_done = 1'b0;
   logic       nak_addr = 1'b0, stretch_en = 1'b0;
   logic       scl_pad, sda_pad;

   assign scl_pad = ~(scl_oe | stretch);
   assign sda_pad = ~(sda_oe | tgt_sda);

   i2c_tx_burst #(.CLK_DIV(4), .FIFO_DEPTH(8), .LEN_W(8)) dut (
      .clk_i(clk), .rstn_i(rstn), .wr_en_i(wr_en), .wr_data_i(wr_data),
      .full_o(full), .empty_o(empty), .start_i(start), .addr_i(addr), .len_i(len),
      .busy_o(busy), .done_o(done), .nak_o(nak), .err_o(err), .ack_cnt_o(ack_cnt),
      .scl_i(scl_pad), .sda_i(sda_pad), .scl_oe_o(scl_oe), .sda_oe_o(sda_oe)
   );

   always #5 clk = ~clk;

   // Target: decodes START/STOP, shifts bits on SCL rise, ACKs bytes, optionally stretches
   always @(negedge clk) begin
      scl_d1 <= scl_pad;
      sda_d1 <= sda_pad;
      if (done) done_cnt <= done_cnt + 1;
      if (scl_d1 && scl_pad && sda_d1 && !sda_pad) begin
         bitn <= 0; byten <= 0; tgt_sda <= 1'b0;
      end else if (scl_d1 && scl_pad && !sda_d1 && sda_pad) begin
         stop_cnt <= stop_cnt + 1;
      end else if (!scl_d1 && scl_pad) begin
         if (bitn < 8) begin
            sr <= {sr[6:0], sda_pad};
            if (bitn == 7 && byten < 16) begin
               bus[byten] <= {sr[6:0], sda_pad};
               byten <= byten + 1;
            end
            bitn <= bitn + 1;
         end else bitn <= 9;
      end else if (scl_d1 && !scl_pad) begin
         if (bitn == 8) tgt_sda <= !(nak_addr && byten == 1);
         else if (bitn == 9) begin tgt_sda <= 1'b0; bitn <= 0; end
         if (stretch_en && !stretch_done && byten == 1 && bitn == 4) begin
            stretch <= 1'b1; stretch_done <= 1'b1; st_cnt <= 0;
         end
      end
      if (stretch && !scl_oe) begin
         if (st_cnt == 10) stretch <= 1'b0;
         else st_cnt <= st_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      wr_en = 1'b1; wr_data = b;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic run(input logic [6:0] a, input logic [7:0] l, output int cyc);
      start = 1'b1; addr = a; len = l;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      cyc = 0;
      while (!done && cyc < 5000) begin
         @(posedge clk); #1;
         cyc++;
      end
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
   endtask

   initial begin
      int cyc, dc0, k;
      logic [7:0] v;
      repeat (3) @(posedge clk); #1;
      chk("rst_scl_oe", scl_oe, 0);
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_nak", nak, 0);
      chk("rst_err", err, 0);
      chk("rst_ack_cnt", ack_cnt, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      rstn = 1'b1;
      @(posedge clk); #1;

      // 1) single byte, ACKed
      push(8'hAA);
      chk("c1_not_empty", empty, 0);
      run(7'h50, 8'd1, cyc);
      chk("c1_cycles", cyc, 320);
      chk("c1_bus0", bus[0], 8'hA0);
      chk("c1_bus1", bus[1], 8'hAA);
      chk("c1_bytes", byten, 2);
      chk("c1_ack_cnt", ack_cnt, 1);
      chk("c1_nak", nak, 0);
      chk("c1_err", err, 0);
      chk("c1_empty", empty, 1);

      // 2) address NAKed, FIFO untouched
      push(8'h55); push(8'hF0);
      nak_addr = 1'b1;
      k = stop_cnt;
      run(7'h50, 8'd2, cyc);
      nak_addr = 1'b0;
      chk("c2_cycles", cyc, 176);
      chk("c2_nak", nak, 1);
      chk("c2_stop", stop_cnt - k, 1);
      chk("c2_bytes", byten, 1);
      chk("c2_empty", empty, 0);
      chk("c2_ack_cnt", ack_cnt, 0);
      // the two bytes left behind go out next
      run(7'h50, 8'd2, cyc);
      chk("c2b_cycles", cyc, 464);
      chk("c2b_bus1", bus[1], 8'h55);
      chk("c2b_bus2", bus[2], 8'hF0);
      chk("c2b_nak_cleared", nak, 0);
      chk("c2b_empty", empty, 1);

      // 3) underflow on the third byte
      push(8'h77); push(8'h33);
      dc0 = done_cnt;
      run(7'h21, 8'd3, cyc);
      chk("c3_cycles", cyc, 464);
      chk("c3_bus0", bus[0], 8'h42);
      chk("c3_bus1", bus[1], 8'h77);
      chk("c3_bus2", bus[2], 8'h33);
      chk("c3_err", err, 1);
      chk("c3_nak", nak, 0);
      chk("c3_ack_cnt", ack_cnt, 2);
      chk("c3_done_pulses", done_cnt - dc0, 1);

      // 4) fill past full, then an 8-byte burst
      for (int i = 0; i < 9; i++) begin
         v = 8'h11 * 8'(i + 1);
         push(v);
         if (i == 6) chk("c4_full_after7", full, 0);
         if (i == 7) chk("c4_full_after8", full, 1);
      end
      chk("c4_full_after9", full, 1);
      run(7'h50, 8'd8, cyc);
      chk("c4_cycles", cyc, 1328);
      chk("c4_bytes", byten, 9);
      for (int i = 0; i < 8; i++) begin
         v = 8'h11 * 8'(i + 1);
         chk("c4_data", bus[i + 1], v);
      end
      chk("c4_ack_cnt", ack_cnt, 8);
      chk("c4_empty", empty, 1);
      chk("c4_err", err, 0);

      // 5) target stretches SCL for 10 cycles during data bit 3
      push(8'hAA);
      stretch_en = 1'b1;
      run(7'h50, 8'd1, cyc);
      stretch_en = 1'b0;
      chk("c5_cycles", cyc, 330);
      chk("c5_bus1", bus[1], 8'hAA);
      chk("c5_ack_cnt", ack_cnt, 1);

      // 6) reset in the middle of data bit 4
      push(8'h00);
      start = 1'b1; addr = 7'h50; len = 8'd1;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      while (!(byten == 1 && bitn == 3) && k < 2000) begin
         @(posedge clk); #1;
         k++;
      end
      chk("c6_reach_bit4", (k < 2000), 1);
      repeat (12) @(posedge clk); #1;
      chk("c6_pre_scl_oe", scl_oe, 1);
      chk("c6_pre_sda_oe", sda_oe, 1);
      rstn = 1'b0;
      #1;
      chk("c6_scl_oe", scl_oe, 0);
      chk("c6_sda_oe", sda_oe, 0);
      chk("c6_busy", busy, 0);
      chk("c6_empty", empty, 1);
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (2) @(posedge clk); #1;
      push(8'h5A);
      run(7'h50, 8'd1, cyc);
      chk("c6_cycles", cyc, 320);
      chk("c6_bus0", bus[0], 8'hA0);
      chk("c6_bus1", bus[1], 8'h5A);
      chk("c6_ack_cnt", ack_cnt, 1);
      chk("c6_err", err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
